// File: rtl/lab_dig_pkg.sv
// -----------------------------------------------------------------------------
// lab_dig_pkg
// Shared definitions for the lab datapath counters.
//   DIR_UP / DIR_DOWN : encoding of the counter direction input
//   clog2()           : ceiling log2, used for elaboration-time width checks
// Ports: none (package).
// -----------------------------------------------------------------------------
package lab_dig_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Number of bits needed to represent the values 0..v-1 (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_m_ud_if.sv
// -----------------------------------------------------------------------------
// contador_m_ud_if
// Control/data bundle of the modulo-M up/down counter.
//   clr  : synchronous clear, active-low
//   ld   : synchronous load, active-low
//   ent  : count enable T, also gates rco
//   enp  : count enable P
//   dir  : 1 = up, 0 = down
//   D    : load value (N bits)
//   Q    : count value (N bits)
//   rco  : combinational ripple carry/borrow
//   fim  : registered one-cycle pulse after a terminal-count event
// Modports: master drives the controls, slave is the counter.
// -----------------------------------------------------------------------------
interface contador_m_ud_if #(
    parameter int N = 4
);
    logic         clr;
    logic         ld;
    logic         ent;
    logic         enp;
    logic         dir;
    logic [N-1:0] D;
    logic [N-1:0] Q;
    logic         rco;
    logic         fim;

    modport master (
        output clr, ld, ent, enp, dir, D,
        input  Q, rco, fim
    );

    modport slave (
        input  clr, ld, ent, enp, dir, D,
        output Q, rco, fim
    );
endinterface

// File: rtl/contador_m_ud_term.sv
// -----------------------------------------------------------------------------
// contador_m_ud_term
// Combinational terminal-value detector for the modulo-M counter.
// Ports:
//   q      in  N  current count
//   at_max out 1  q == M-1
//   at_min out 1  q == 0
// -----------------------------------------------------------------------------
module contador_m_ud_term #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic [N-1:0] q,
    output logic         at_max,
    output logic         at_min
);
    localparam logic [N-1:0] TOP = N'(M - 1);

    assign at_max = (q == TOP);
    assign at_min = (q == '0);
endmodule

// File: rtl/contador_m_ud.sv
// -----------------------------------------------------------------------------
// contador_m_ud
// Synchronous modulo-M binary counter, N bits wide, with up/down direction,
// 74163-style clear/load/enables, direction-aware ripple carry and a
// registered terminal-count pulse. Cascadable through ent/rco.
//
// Ports:
//   clock  in  1   rising-edge clock
//   reset  in  1   asynchronous reset, active-high (Q=0, fim=0)
//   bus    slave   contador_m_ud_if: clr, ld, ent, enp, dir, D -> Q, rco, fim
//
// Edge priority: clear, then clamped load (D >= M loads M-1), then count.
//
// Build option: define CONTADOR_M_UD_SAT_EN for saturating mode, where an
// enabled count at the terminal value holds Q (up at M-1, down at 0) and
// still pulses fim. Without it the counter wraps around.
// -----------------------------------------------------------------------------
module contador_m_ud
    import lab_dig_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic            clock,
    input  logic            reset,
    contador_m_ud_if.slave  bus
);
    localparam logic [N-1:0] TOP = N'(M - 1);
    localparam logic [N:0]   MOD = (N + 1)'(M);
    localparam logic [N:0]   ONE = (N + 1)'(1);

    if (N < 1 || N > 16) begin : g_bad_n
        $error("contador_m_ud: N=%0d outside 1..16", N);
    end
    if (M < 2 || clog2(M) > N) begin : g_bad_m
        $error("contador_m_ud: M=%0d outside 2..2**N (N=%0d)", M, N);
    end

    logic [N-1:0] q;
    logic         fim_q;
    logic         at_max;
    logic         at_min;
    logic         rco;
    logic [N:0]   step;
    logic [N-1:0] load_val;
    logic         unused_carry;

    contador_m_ud_term #(
        .N (N),
        .M (M)
    ) u_term (
        .q      (q),
        .at_max (at_max),
        .at_min (at_min)
    );

    // Carry/borrow of the terminal value in the current direction.
    assign rco = bus.ent && (((bus.dir == DIR_UP)   && at_max) ||
                             ((bus.dir == DIR_DOWN) && at_min));

    // Non-terminal increment/decrement at N+1 bits; the terminal case is
    // handled explicitly below, so the carry bit is never needed.
    assign step         = (bus.dir == DIR_UP) ? ({1'b0, q} + ONE) : ({1'b0, q} - ONE);
    assign unused_carry = step[N];

    // Out-of-range load values clamp to the top of the count range.
    assign load_val = ({1'b0, bus.D} < MOD) ? bus.D : TOP;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q     <= '0;
            fim_q <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            if (!bus.clr) begin
                q <= '0;
            end else if (!bus.ld) begin
                q <= load_val;
            end else if (bus.ent && bus.enp) begin
                if (rco) begin
                    fim_q <= 1'b1;
`ifdef CONTADOR_M_UD_SAT_EN
                    q <= q;
`else
                    q <= (bus.dir == DIR_UP) ? '0 : TOP;
`endif
                end else begin
                    q <= step[N-1:0];
                end
            end
        end
    end

    assign bus.Q   = q;
    assign bus.fim = fim_q;
    assign bus.rco = rco;
endmodule

// File: tb/tb_contador_m_ud.sv
// -----------------------------------------------------------------------------
// tb_contador_m_ud
// Directed bench for contador_m_ud with N=4, M=10. Each clock step pushes
// the value expected from a behavioural model into a scoreboard queue and
// pops it after the edge to compare with Q/fim; rco and a few landmark
// values are checked directly. Expectations follow CONTADOR_M_UD_SAT_EN.
// -----------------------------------------------------------------------------
module tb_contador_m_ud;
    localparam int N = 4;
    localparam int M = 10;

    typedef struct {
        logic [N-1:0] q;
        logic         fim;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    contador_m_ud_if #(.N(N)) bus ();

    contador_m_ud #(.N(N), .M(M)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mq       = 0;   // model count
    exp_t sb[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_rco();
        return bus.ent && ((bus.dir && mq == M - 1) || (!bus.dir && mq == 0));
    endfunction

    task automatic chk_rco(input string tag);
        chk({tag, "_rco"}, 16'(bus.rco), 16'(model_rco()));
    endtask

    // Model one edge, push expectation, clock it, pop and compare.
    task automatic tick(input string tag);
        exp_t e;
        int   nq;
        logic nf;
        nq = mq;
        nf = 1'b0;
        if (!bus.clr) begin
            nq = 0;
        end else if (!bus.ld) begin
            nq = (int'(bus.D) < M) ? int'(bus.D) : M - 1;
        end else if (bus.ent && bus.enp) begin
            if (model_rco()) begin
                nf = 1'b1;
`ifdef CONTADOR_M_UD_SAT_EN
                nq = mq;
`else
                nq = bus.dir ? 0 : M - 1;
`endif
            end else begin
                nq = bus.dir ? mq + 1 : mq - 1;
            end
        end
        e.q   = N'(nq);
        e.fim = nf;
        sb.push_back(e);
        mq = nq;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q"},   16'(bus.Q),   16'(e.q));
            chk({tag, "_fim"}, 16'(bus.fim), 16'(e.fim));
            chk({tag, "_range"}, 16'(int'(bus.Q) < M), 16'd1);
        end
    endtask

    task automatic set_in(input logic clr, input logic ld, input logic ent,
                          input logic enp, input logic dir, input logic [N-1:0] d);
        bus.clr = clr;
        bus.ld  = ld;
        bus.ent = ent;
        bus.enp = enp;
        bus.dir = dir;
        bus.D   = d;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        #12;
        chk("reset_q",   16'(bus.Q),   16'd0);
        chk("reset_fim", 16'(bus.fim), 16'd0);
        chk("reset_rco", 16'(bus.rco), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        mq = 0;

        // Up count 0..9 then wrap
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0);
        chk_rco("up_start");
        for (int i = 0; i < 11; i++) begin
            tick("up");
            chk_rco("up");
            if (i == 8) chk("up_at9_rco", 16'(bus.rco), 16'd1);
        end
        // After 11 edges from 0: wrapped past 9 then one more count.
`ifdef CONTADOR_M_UD_SAT_EN
        chk("up_landmark", 16'(bus.Q), 16'd9);
`else
        chk("up_landmark", 16'(bus.Q), 16'd1);
`endif

        // Down count from 2: 1,0,9,8
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        tick("dn_load");
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            tick("down");
            chk_rco("down");
            if (i == 1) chk("down_at0_rco", 16'(bus.rco), 16'd1);
        end
`ifndef CONTADOR_M_UD_SAT_EN
        chk("down_landmark", 16'(bus.Q), 16'd8);
`endif

        // Loads: plain, clamped, clear beats load
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        tick("ld7");
        chk("ld7_val", 16'(bus.Q), 16'd7);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
        tick("ld13");
        chk("ld13_clamp", 16'(bus.Q), 16'd9);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        tick("clr_ld");
        chk("clr_ld_val", 16'(bus.Q), 16'd0);

        // Load at the terminal value with enables high: load wins, no fim
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        tick("ld9");
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        tick("ld_over_cnt");
        chk("ld_over_cnt_fim", 16'(bus.fim), 16'd0);

        // Enables: ent only at 9 holds, rco stays valid
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        tick("en_ld9");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0);
        tick("ent_only");
        chk("ent_only_hold", 16'(bus.Q), 16'd9);
        chk("ent_only_rco", 16'(bus.rco), 16'd1);
        bus.ent = 1'b0;
        bus.enp = 1'b1;
        #1;
        chk_rco("ent0");
        chk("ent0_rco", 16'(bus.rco), 16'd0);
        tick("enp_only");

        // Direction flip at 0 changes rco with no edge
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0);
        tick("clr0");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0);
        #1;
        chk("dir_up_at0_rco", 16'(bus.rco), 16'd0);
        bus.dir = 1'b0;
        #1;
        chk("dir_dn_at0_rco", 16'(bus.rco), 16'd1);

        // Async reset mid-count at 6
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0);
        for (int i = 0; i < 6; i++) tick("pre_rst");
        chk("pre_rst_q", 16'(bus.Q), 16'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_q",   16'(bus.Q),   16'd0);
        chk("async_rst_fim", 16'(bus.fim), 16'd0);
        mq = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("post_rst");
        chk("post_rst_q", 16'(bus.Q), 16'd3);

        // Terminal behaviour from 8 upward: wrap or saturate
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        tick("sat_ld8");
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0);
        tick("sat_to9");
        chk("sat_to9_q", 16'(bus.Q), 16'd9);
        tick("sat_edge1");
`ifdef CONTADOR_M_UD_SAT_EN
        chk("term_edge1_q", 16'(bus.Q), 16'd9);
`else
        chk("term_edge1_q", 16'(bus.Q), 16'd0);
`endif
        chk("term_edge1_fim", 16'(bus.fim), 16'd1);
        tick("sat_edge2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
